// File: rtl/issue_queue_lsu_ooo_if.sv
// rtl/issue_queue_lsu_ooo_if.sv - dispatch/wakeup/issue bundle for the LSU issue queue
interface issue_queue_lsu_ooo_if #(
    parameter int DEPTH     = 8,
    parameter int ENQ_W     = 2,
    parameter int WAKE_W    = 4,
    parameter int PRF_W     = 7,
    parameter int PAYLOAD_W = 96
) ();
    logic                        flush;
    logic [ENQ_W-1:0]            enq_valid;
    logic [ENQ_W*PAYLOAD_W-1:0]  enq_payload;
    logic [ENQ_W*PRF_W-1:0]      enq_src0;
    logic [ENQ_W*PRF_W-1:0]      enq_src1;
    logic [ENQ_W*2-1:0]          enq_src_rdy;
    logic [ENQ_W-1:0]            enq_is_store;
    logic                        enq_ready;
    logic [WAKE_W-1:0]           wake_valid;
    logic [WAKE_W*PRF_W-1:0]     wake_tag;
    logic                        lsu_busy;
    logic                        iss_valid;
    logic [PAYLOAD_W-1:0]        iss_payload;
    logic [PRF_W-1:0]            iss_src0;
    logic [PRF_W-1:0]            iss_src1;
    logic                        iss_is_store;
    logic [$clog2(DEPTH+1)-1:0]  count;

    modport master (
        output flush, enq_valid, enq_payload, enq_src0, enq_src1, enq_src_rdy, enq_is_store,
        output wake_valid, wake_tag, lsu_busy,
        input  enq_ready, iss_valid, iss_payload, iss_src0, iss_src1, iss_is_store, count
    );

    modport slave (
        input  flush, enq_valid, enq_payload, enq_src0, enq_src1, enq_src_rdy, enq_is_store,
        input  wake_valid, wake_tag, lsu_busy,
        output enq_ready, iss_valid, iss_payload, iss_src0, iss_src1, iss_is_store, count
    );
endinterface

// File: rtl/issue_queue_lsu_ooo.sv
// rtl/issue_queue_lsu_ooo.sv - compacting age-ordered issue queue for the load/store pipe
module issue_queue_lsu_ooo #(
    parameter int DEPTH      = 8,
    parameter int ENQ_W      = 2,
    parameter int WAKE_W     = 4,
    parameter int PRF_W      = 7,
    parameter int PAYLOAD_W  = 96,
    parameter int ORDER_MODE = 0
) (
    input logic clk,
    input logic rst,
    issue_queue_lsu_ooo_if.slave io
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] ENQ_LIM = CW'(DEPTH-ENQ_W);

    typedef struct packed {
        logic                 valid;
        logic                 store;
        logic                 rdy0;
        logic                 rdy1;
        logic [PRF_W-1:0]     src0;
        logic [PRF_W-1:0]     src1;
        logic [PAYLOAD_W-1:0] payload;
    } slot_t;

    slot_t         slot_q [DEPTH];
    slot_t         slot_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] n_enq;
    logic [DEPTH-1:0] elig;
    logic          iss_fire;
    logic          enq_ok;
    int            sel;
    int            base;
    slot_t         iss_slot;

    function automatic logic woken(input logic [PRF_W-1:0] tag,
                                   input logic [WAKE_W-1:0] wv,
                                   input logic [WAKE_W*PRF_W-1:0] wt);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WAKE_W; w++)
            if (wv[w] && wt[w*PRF_W +: PRF_W] == tag) hit = 1'b1;
        return hit;
    endfunction

    // Select: a store only ever issues from the head; a load waits behind any older store.
    always_comb begin : select
        logic older_store;
        logic ok;
        elig        = '0;
        older_store = 1'b0;
        ok          = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (ORDER_MODE == 0) ok = slot_q[j].store ? (j == 0) : !older_store;
            else                 ok = (j == 0);
            elig[j] = slot_q[j].valid & slot_q[j].rdy0 & slot_q[j].rdy1 & ~io.lsu_busy & ok;
            if (slot_q[j].valid && slot_q[j].store) older_store = 1'b1;
        end
        sel      = 0;
        iss_fire = 1'b0;
        iss_slot = '0;
        for (int j = DEPTH-1; j >= 0; j--) begin
            if (elig[j]) begin
                sel      = j;
                iss_fire = 1'b1;
                iss_slot = slot_q[j];
            end
        end
        if (io.flush) begin
            iss_fire = 1'b0;
            iss_slot = '0;
        end
    end

    assign io.enq_ready    = (count_q <= ENQ_LIM);
    assign io.count        = count_q;
    assign io.iss_valid    = iss_fire;
    assign io.iss_payload  = iss_slot.payload;
    assign io.iss_src0     = iss_slot.src0;
    assign io.iss_src1     = iss_slot.src1;
    assign io.iss_is_store = iss_slot.store;

    always_comb begin : next_state
        enq_ok = io.enq_ready & ~io.flush;
        base   = int'(count_q) - (iss_fire ? 1 : 0);
        n_enq  = '0;
        for (int k = 0; k < ENQ_W; k++)
            if (enq_ok && io.enq_valid[k]) n_enq = n_enq + CW'(1);
        for (int j = 0; j < DEPTH; j++) begin
            slot_d[j] = '0;
            if (iss_fire && j >= sel) begin
                for (int i = 0; i < DEPTH; i++)
                    if (i == j + 1) slot_d[j] = slot_q[i];
            end else begin
                slot_d[j] = slot_q[j];
            end
            if (slot_d[j].valid) begin
                slot_d[j].rdy0 = slot_d[j].rdy0 | woken(slot_d[j].src0, io.wake_valid, io.wake_tag);
                slot_d[j].rdy1 = slot_d[j].rdy1 | woken(slot_d[j].src1, io.wake_valid, io.wake_tag);
            end
            // Entering lanes land after this cycle's compaction.
            for (int k = 0; k < ENQ_W; k++) begin
                if (enq_ok && io.enq_valid[k] && j == base + k) begin
                    slot_d[j].valid   = 1'b1;
                    slot_d[j].store   = io.enq_is_store[k];
                    slot_d[j].src0    = io.enq_src0[k*PRF_W +: PRF_W];
                    slot_d[j].src1    = io.enq_src1[k*PRF_W +: PRF_W];
                    slot_d[j].payload = io.enq_payload[k*PAYLOAD_W +: PAYLOAD_W];
                    slot_d[j].rdy0    = io.enq_src_rdy[2*k] |
                                        woken(io.enq_src0[k*PRF_W +: PRF_W], io.wake_valid, io.wake_tag);
                    slot_d[j].rdy1    = io.enq_src_rdy[2*k+1] |
                                        woken(io.enq_src1[k*PRF_W +: PRF_W], io.wake_valid, io.wake_tag);
                end
            end
            if (io.flush) slot_d[j] = '0;
        end
        count_d = io.flush ? '0 : count_q - CW'(iss_fire) + n_enq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int j = 0; j < DEPTH; j++) slot_q[j] <= '0;
        end else begin
            count_q <= count_d;
            for (int j = 0; j < DEPTH; j++) slot_q[j] <= slot_d[j];
        end
    end
endmodule

// File: tb/tb_issue_queue_lsu_ooo.sv
// tb/tb_issue_queue_lsu_ooo.sv - directed self-checking bench for issue_queue_lsu_ooo
module tb_issue_queue_lsu_ooo;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    issue_queue_lsu_ooo_if #(.DEPTH(8), .ENQ_W(2), .WAKE_W(4), .PRF_W(7), .PAYLOAD_W(96)) io0 ();
    issue_queue_lsu_ooo_if #(.DEPTH(8), .ENQ_W(2), .WAKE_W(4), .PRF_W(7), .PAYLOAD_W(96)) io1 ();

    issue_queue_lsu_ooo #(.DEPTH(8), .ENQ_W(2), .WAKE_W(4), .PRF_W(7), .PAYLOAD_W(96), .ORDER_MODE(0))
        dut0 (.clk(clk), .rst(rst), .io(io0));
    issue_queue_lsu_ooo #(.DEPTH(8), .ENQ_W(2), .WAKE_W(4), .PRF_W(7), .PAYLOAD_W(96), .ORDER_MODE(1))
        dut1 (.clk(clk), .rst(rst), .io(io1));

    assign io1.flush        = io0.flush;
    assign io1.enq_valid    = io0.enq_valid;
    assign io1.enq_payload  = io0.enq_payload;
    assign io1.enq_src0     = io0.enq_src0;
    assign io1.enq_src1     = io0.enq_src1;
    assign io1.enq_src_rdy  = io0.enq_src_rdy;
    assign io1.enq_is_store = io0.enq_is_store;
    assign io1.wake_valid   = io0.wake_valid;
    assign io1.wake_tag     = io0.wake_tag;
    assign io1.lsu_busy     = io0.lsu_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        io0.flush        = 1'b0;
        io0.enq_valid    = '0;
        io0.enq_payload  = '0;
        io0.enq_src0     = '0;
        io0.enq_src1     = '0;
        io0.enq_src_rdy  = '0;
        io0.enq_is_store = '0;
        io0.wake_valid   = '0;
        io0.wake_tag     = '0;
    endtask

    task automatic lane(input int k, input logic [95:0] p, input logic [6:0] s0, input logic [6:0] s1,
                        input logic [1:0] rdy, input logic st);
        io0.enq_valid[k]            = 1'b1;
        io0.enq_payload[k*96 +: 96] = p;
        io0.enq_src0[k*7 +: 7]      = s0;
        io0.enq_src1[k*7 +: 7]      = s1;
        io0.enq_src_rdy[k*2 +: 2]   = rdy;
        io0.enq_is_store[k]         = st;
    endtask

    task automatic do_flush();
        io0.flush = 1'b1;
        tick();
        io0.flush = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clr();
        io0.lsu_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 128'(io0.count), 128'd0);
        chk("rst_iss_valid", 128'(io0.iss_valid), 128'd0);
        chk("rst_enq_ready", 128'(io0.enq_ready), 128'd1);
        chk("rst_iss_payload", 128'(io0.iss_payload), 128'd0);
        rst = 1'b0;

        // two ready loads drain in order
        lane(0, 96'hA1, 7'd1, 7'd2, 2'b11, 1'b0);
        lane(1, 96'hA2, 7'd3, 7'd4, 2'b11, 1'b0);
        tick(); clr(); #1;
        chk("t1_count2", 128'(io0.count), 128'd2);
        chk("t1_iss0_valid", 128'(io0.iss_valid), 128'd1);
        chk("t1_iss0_payload", 128'(io0.iss_payload), 128'hA1);
        chk("t1_iss0_src1", 128'(io0.iss_src1), 128'd2);
        tick(); #1;
        chk("t1_count1", 128'(io0.count), 128'd1);
        chk("t1_iss1_payload", 128'(io0.iss_payload), 128'hA2);
        tick(); #1;
        chk("t1_count0", 128'(io0.count), 128'd0);
        chk("t1_empty_valid", 128'(io0.iss_valid), 128'd0);

        // fill to full with the LSU stalled
        io0.lsu_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lane(0, 96'(32'hB0 + 2*i), 7'd8, 7'd9, 2'b11, 1'b0);
            lane(1, 96'(32'hB1 + 2*i), 7'd8, 7'd9, 2'b11, 1'b0);
            tick(); clr();
        end
        #1;
        chk("t2_count6", 128'(io0.count), 128'd6);
        chk("t2_ready6", 128'(io0.enq_ready), 128'd1);
        lane(0, 96'hB6, 7'd8, 7'd9, 2'b11, 1'b0);
        lane(1, 96'hB7, 7'd8, 7'd9, 2'b11, 1'b0);
        tick(); clr(); #1;
        chk("t2_count8", 128'(io0.count), 128'd8);
        chk("t2_ready8", 128'(io0.enq_ready), 128'd0);
        lane(0, 96'hBE, 7'd8, 7'd9, 2'b11, 1'b0);
        lane(1, 96'hBF, 7'd8, 7'd9, 2'b11, 1'b0);
        tick(); clr(); #1;
        chk("t2_drop_count", 128'(io0.count), 128'd8);
        io0.lsu_busy = 1'b0;
        #1;
        chk("t2_full_iss_valid", 128'(io0.iss_valid), 128'd1);
        chk("t2_full_iss_payload", 128'(io0.iss_payload), 128'hB0);
        tick(); #1;
        chk("t2_count7", 128'(io0.count), 128'd7);
        do_flush(); #1;
        chk("t2_flush_count", 128'(io0.count), 128'd0);

        // issue and enqueue together at count 6
        io0.lsu_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lane(0, 96'hC8, 7'd8, 7'd9, 2'b11, 1'b0);
            lane(1, 96'hC9, 7'd8, 7'd9, 2'b11, 1'b0);
            tick(); clr();
        end
        io0.lsu_busy = 1'b0;
        lane(0, 96'hCA, 7'd8, 7'd9, 2'b11, 1'b0);
        lane(1, 96'hCB, 7'd8, 7'd9, 2'b11, 1'b0);
        #1;
        chk("t2b_iss_valid", 128'(io0.iss_valid), 128'd1);
        tick(); clr(); #1;
        chk("t2b_count7", 128'(io0.count), 128'd7);
        do_flush();

        // store waiting on src1 blocks a younger ready load until woken
        lane(0, 96'hC0, 7'd3, 7'd5, 2'b01, 1'b1);
        lane(1, 96'hC1, 7'd6, 7'd7, 2'b11, 1'b0);
        tick(); clr(); #1;
        chk("t3_blocked", 128'(io0.iss_valid), 128'd0);
        chk("t3_count2", 128'(io0.count), 128'd2);
        io0.wake_valid      = 4'b0010;
        io0.wake_tag[7 +: 7] = 7'd5;
        #1;
        chk("t3_wake_cycle", 128'(io0.iss_valid), 128'd0);
        tick(); clr(); #1;
        chk("t3_store_valid", 128'(io0.iss_valid), 128'd1);
        chk("t3_store_flag", 128'(io0.iss_is_store), 128'd1);
        chk("t3_store_payload", 128'(io0.iss_payload), 128'hC0);
        tick(); #1;
        chk("t3_load_payload", 128'(io0.iss_payload), 128'hC1);
        chk("t3_load_flag", 128'(io0.iss_is_store), 128'd0);
        tick(); #1;
        chk("t3_count0", 128'(io0.count), 128'd0);
        do_flush();

        // load bypass: allowed in mode 0, not in mode 1
        lane(0, 96'hD0, 7'd9, 7'd10, 2'b10, 1'b0);
        lane(1, 96'hD1, 7'd11, 7'd12, 2'b11, 1'b0);
        tick(); clr(); #1;
        chk("t4_m0_valid", 128'(io0.iss_valid), 128'd1);
        chk("t4_m0_payload", 128'(io0.iss_payload), 128'hD1);
        chk("t4_m1_valid", 128'(io1.iss_valid), 128'd0);
        tick(); #1;
        chk("t4_m0_count1", 128'(io0.count), 128'd1);
        chk("t4_m0_head_blocked", 128'(io0.iss_valid), 128'd0);
        do_flush();

        // wakeup of slot 3 while slot 1 issues
        io0.lsu_busy = 1'b1;
        lane(0, 96'hE0, 7'd20, 7'd1, 2'b10, 1'b0);
        lane(1, 96'hE1, 7'd2, 7'd3, 2'b11, 1'b0);
        tick(); clr();
        lane(0, 96'hE2, 7'd21, 7'd1, 2'b10, 1'b0);
        lane(1, 96'hE3, 7'd22, 7'd1, 2'b10, 1'b0);
        tick(); clr();
        io0.lsu_busy          = 1'b0;
        io0.wake_valid        = 4'b1000;
        io0.wake_tag[21 +: 7] = 7'd22;
        #1;
        chk("t5_count4", 128'(io0.count), 128'd4);
        chk("t5_iss_payload", 128'(io0.iss_payload), 128'hE1);
        tick(); clr(); #1;
        chk("t5_count3", 128'(io0.count), 128'd3);
        chk("t5_woken_valid", 128'(io0.iss_valid), 128'd1);
        chk("t5_woken_payload", 128'(io0.iss_payload), 128'hE3);
        do_flush();

        // flush beats same-cycle issue and enqueue
        io0.lsu_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            lane(0, 96'hF0, 7'd1, 7'd2, 2'b11, 1'b0);
            lane(1, 96'hF1, 7'd1, 7'd2, 2'b11, 1'b0);
            tick(); clr();
        end
        lane(0, 96'hF2, 7'd1, 7'd2, 2'b11, 1'b0);
        tick(); clr(); #1;
        chk("t6_count5", 128'(io0.count), 128'd5);
        io0.lsu_busy = 1'b0;
        io0.flush    = 1'b1;
        lane(0, 96'hF3, 7'd1, 7'd2, 2'b11, 1'b0);
        lane(1, 96'hF4, 7'd1, 7'd2, 2'b11, 1'b0);
        #1;
        chk("t6_flush_iss_valid", 128'(io0.iss_valid), 128'd0);
        tick(); clr(); #1;
        chk("t6_flush_count", 128'(io0.count), 128'd0);

        // async reset mid-fill
        io0.lsu_busy = 1'b1;
        lane(0, 96'h11, 7'd1, 7'd2, 2'b11, 1'b0);
        lane(1, 96'h12, 7'd1, 7'd2, 2'b11, 1'b0);
        tick(); clr(); #1;
        chk("t6_fill_count2", 128'(io0.count), 128'd2);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_count", 128'(io0.count), 128'd0);
        chk("t6_async_ready", 128'(io0.enq_ready), 128'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
